sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares one single-port SRAM (sync write, async read) between two requesters.
//  Round-robin arbitration, one access per cycle, registered read responses.
//  After reset or clr_req it walks every address and writes zero, then serves requests.
//  Sits between the core's two memory clients and the sram instance.
// PARAMETERS
//  DATA_W  64  data width; matches the SRAM word width
//  ADDR_W  6   address width; matches the SRAM address width
//  DEPTH   64  number of words cleared by the init walk (<= 2**ADDR_W)
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst_n        in   1       async active-low reset
//  clr_req      in   1       pulse: start a clear walk (sampled in RUN only)
//  clear_busy   out  1       high while in CLEAR state
//  reqN_valid   in   1       (N=0,1) requester N has an access pending
//  reqN_we      in   1       1=write, 0=read
//  reqN_addr    in   ADDR_W  access address
//  reqN_wdata   in   DATA_W  write data
//  reqN_ready   out  1       grant; transfer when reqN_valid & reqN_ready
//  rspN_valid   out  1       one-cycle pulse, read data for N is on rspN_rdata
//  rspN_rdata   out  DATA_W  read data; held until N's next read response
//  mem_we       out  1       to SRAM write enable
//  mem_addr     out  ADDR_W  to SRAM address
//  mem_d        out  DATA_W  to SRAM write data
//  mem_q        in   DATA_W  from SRAM async read data
// BEHAVIOUR
//  Reset (rst_n=0, async): state=CLEAR, clr_cnt=0, rr_last=1 (req0 favoured),
//   rspN_valid=0, rspN_rdata=0. clear_busy=1 immediately (from state).
//  FSM: CLEAR -> RUN when clr_cnt==DEPTH-1 on a clock edge; RUN -> CLEAR when clr_req=1
//   (clr_cnt loads 0). clr_req during CLEAR is ignored (no restart).
//  CLEAR: mem_we=1, mem_addr=clr_cnt, mem_d=0; clr_cnt++ per cycle; both ready=0.
//   Walk takes exactly DEPTH cycles; first RUN cycle is DEPTH cycles after reset release.
//  RUN arbitration (combinational, same cycle):
//   only one valid -> grant it; both valid -> grant requester != rr_last;
//   none valid -> no grant, mem_we=0, rr_last unchanged.
//   reqN_ready = (state==RUN) & grant==N; ready never asserted without valid.
//   rr_last <= granted index on each transfer.
//  Access: granted request drives mem_addr/mem_d directly; mem_we = grant & reqN_we.
//   Write lands at the transfer edge. Read: mem_q captured into rspN_rdata at the
//   transfer edge; rspN_valid=1 on the following cycle only (latency 1).
//   Writes produce no response.
//  Ordering: read of an address written in the previous cycle returns new data.
//   Back-to-back reads from one requester give back-to-back rsp pulses.
//  Non-granted idle outputs: mem_addr=0, mem_d=0 when no grant in RUN.
//  clr_req in same cycle as a transfer: transfer completes (RUN that cycle), CLEAR next.
//   A read accepted in the last RUN cycle still gets its rsp pulse in the first CLEAR cycle.
//  Requester must hold valid/we/addr/wdata stable until ready; block does not buffer.
//  Reset mid-CLEAR or mid-RUN: pending rsp dropped, walk restarts at address 0.
// TESTING
//  1 Reset release, no requests -> clear_busy=1 for 64 cycles, mem_we=1 addr 0..63 d=0,
//    then clear_busy=0; any read returns 0.
//  2 req0 write 0x12 @5, next cycle req0 read @5 -> ready same cycle, rsp0_valid one
//    cycle later with rsp0_rdata=0x12; rsp1_valid stays 0.
//  3 Both valid continuously, reads @1 (req0) and @2 (req1) -> grants alternate 0,1,0,1
//    starting with 0; each rsp pulses one cycle after its grant.
//  4 req1 only, valid 4 cycles -> granted all 4 (no idle slots); then req0+req1 ->
//    req0 granted first.
//  5 clr_req with req0 read accepted same cycle -> rsp0_valid pulses during first
//    CLEAR cycle, ready=0 for next 64 cycles, prior data reads 0 afterwards.
//  6 rst_n low mid-walk (clr_cnt=30) -> outputs reset asynchronously, walk restarts at 0.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for sram_arbiter: two request channels plus their
// read-response channels. The arbiter connects via the slave modport, and the
// memory clients connect via the master modport.
interface sram_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
);
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM
// (synchronous write, asynchronous read). After reset or a clear request it
// writes zero to every word, then serves one access per cycle. Read data is
// captured at the transfer edge and returned one cycle later.
module sram_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clear_busy,
  sram_arbiter_if.slave     bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              rr_last_reg;
  logic              rsp0_valid_reg;
  logic              rsp1_valid_reg;
  logic [DATA_W-1:0] rsp0_rdata_reg;
  logic [DATA_W-1:0] rsp1_rdata_reg;

  logic              grant_any;
  logic              grant_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Pick a requester this cycle; on contention favour the one not served last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (state_reg == ST_RUN) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_any = 1'b1;
        grant_idx = ~rr_last_reg;
      end else if (bus.req0_valid) begin
        grant_any = 1'b1;
        grant_idx = 1'b0;
      end else if (bus.req1_valid) begin
        grant_any = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  assign sel_we    = grant_idx ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = grant_idx ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = grant_idx ? bus.req1_wdata : bus.req0_wdata;

  assign bus.req0_ready = grant_any & ~grant_idx;
  assign bus.req1_ready = grant_any &  grant_idx;

  assign clear_busy     = (state_reg == ST_CLEAR);
  assign bus.rsp0_valid = rsp0_valid_reg;
  assign bus.rsp1_valid = rsp1_valid_reg;
  assign bus.rsp0_rdata = rsp0_rdata_reg;
  assign bus.rsp1_rdata = rsp1_rdata_reg;

  // SRAM port mux: clear walk writes zeros, otherwise the granted request
  // drives the port directly; idle cycles park the bus at zero.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_d    = '0;
    if (state_reg == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt_reg;
    end else if (grant_any) begin
      mem_we   = sel_we;
      mem_addr = sel_addr;
      mem_d    = sel_wdata;
    end
  end

  // Controller state, clear walk counter, round-robin pointer and read responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_CLEAR;
      clr_cnt_reg    <= '0;
      rr_last_reg    <= 1'b1;
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      rsp0_rdata_reg <= '0;
      rsp1_rdata_reg <= '0;
    end else begin
      // Response pulses last exactly one cycle.
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          if (clr_cnt_reg == LAST_ADDR) begin
            state_reg   <= ST_RUN;
            clr_cnt_reg <= '0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          if (grant_any) begin
            rr_last_reg <= grant_idx;
            if (!sel_we) begin
              if (grant_idx) begin
                rsp1_valid_reg <= 1'b1;
                rsp1_rdata_reg <= mem_q;
              end else begin
                rsp0_valid_reg <= 1'b1;
                rsp0_rdata_reg <= mem_q;
              end
            end
          end
          // A transfer in the same cycle still completes; the walk starts next.
          if (clr_req) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg   <= ST_CLEAR;
          clr_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed accesses push expected read
// data into per-requester queues, and a monitor pops and compares on each
// response pulse. An SRAM model (sync write, async read) sits on the memory port.
module tb_sram_arbiter;
  localparam int DW     = 64;
  localparam int AW     = 6;
  localparam int DEPTH  = 64;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_req = 1'b0;
  logic          clear_busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] sram [DEPTH];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int grant_log[$];
  logic [DW-1:0] mon_e0;
  logic [DW-1:0] mon_e1;

  sram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  sram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .clear_busy (clear_busy),
    .bus        (bus),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  always #5 clk = ~clk;

  // SRAM model
  always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_d;
  assign mem_q = sram[mem_addr];

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one access and hold it until granted; expected read data is
  // queued at the handshake. hold=1 leaves valid high for a following access.
  task automatic access(input int n, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp,
                        input bit hold, output int waited);
    bit ok;
    bit rdy;
    ok = 1'b0;
    waited = 0;
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = wd;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = wd;
    end
    while (!ok && waited < BUDGET) begin
      @(negedge clk);
      rdy = (n == 0) ? bus.req0_ready : bus.req1_ready;
      if (rdy) ok = 1'b1;
      else waited++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout req%0d addr=%0d actual=no_ready required=ready", n, addr);
    end else begin
      $display("req%0d %s addr=%0d data=%0h granted after %0d wait cycles",
               n, we ? "write" : "read", addr, we ? wd : exp, waited);
      if (!we) begin
        if (n == 0) exp_q0.push_back(exp);
        else exp_q1.push_back(exp);
      end
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (n == 0) bus.req0_valid = 1'b0;
      else bus.req1_valid = 1'b0;
    end
  endtask

  // Walk of DEPTH zero writes, then the controller must leave CLEAR.
  task automatic clear_walk_check();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("clear_walk", {clear_busy, mem_we, mem_addr, mem_d},
            {1'b1, 1'b1, AW'(i), {DW{1'b0}}});
    end
    @(negedge clk);
    check("clear_done", clear_busy, 0);
  endtask

  // Monitor: handshake rules, grant log and response scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((bus.req0_ready && !bus.req0_valid) || (bus.req1_ready && !bus.req1_valid) ||
          (bus.req0_ready && bus.req1_ready) ||
          (clear_busy && (bus.req0_ready || bus.req1_ready))) begin
        errors++;
        $display("FAIL ready_rule actual=r0:%b r1:%b v0:%b v1:%b busy:%b required=single grant to a valid requester in RUN",
                 bus.req0_ready, bus.req1_ready, bus.req0_valid, bus.req1_valid, clear_busy);
      end
      if (bus.req0_ready) grant_log.push_back(0);
      if (bus.req1_ready) grant_log.push_back(1);
      if (bus.rsp0_valid) begin
        checks++;
        if (exp_q0.size() == 0) begin
          errors++;
          $display("FAIL rsp0_unexpected actual=pulse data=%0h required=no pulse", bus.rsp0_rdata);
        end else begin
          mon_e0 = exp_q0.pop_front();
          if (bus.rsp0_rdata !== mon_e0) begin
            errors++;
            $display("FAIL rsp0_data actual=%0h required=%0h", bus.rsp0_rdata, mon_e0);
          end else $display("rsp0 data=%0h as expected", bus.rsp0_rdata);
        end
      end
      if (bus.rsp1_valid) begin
        checks++;
        if (exp_q1.size() == 0) begin
          errors++;
          $display("FAIL rsp1_unexpected actual=pulse data=%0h required=no pulse", bus.rsp1_rdata);
        end else begin
          mon_e1 = exp_q1.pop_front();
          if (bus.rsp1_rdata !== mon_e1) begin
            errors++;
            $display("FAIL rsp1_data actual=%0h required=%0h", bus.rsp1_rdata, mon_e1);
          end else $display("rsp1 data=%0h as expected", bus.rsp1_rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int wsum;
    int exp3[4];
    int exp4[6];
    exp3 = '{0, 1, 0, 1};
    exp4 = '{1, 1, 1, 1, 0, 1};
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;

    // Reset values while rst_n is low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", clear_busy, 1);
    check("reset_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata}, 0);
    check("reset_mem_addr", mem_addr, 0);

    // Test 1: clear walk after reset release, then a read returns zero
    sync();
    rst_n = 1'b1;
    clear_walk_check();
    sync();
    access(1, 1'b0, 6'd7, '0, 64'd0, 0, w);

    // Test 3: alternating grants under continuous contention
    access(1, 1'b1, 6'd1, 64'hA1, '0, 0, w);
    access(1, 1'b1, 6'd2, 64'hB2, '0, 0, w);
    sync();
    grant_log.delete();
    fork
      begin
        access(0, 1'b0, 6'd1, '0, 64'hA1, 1, w);
        access(0, 1'b0, 6'd1, '0, 64'hA1, 0, w);
      end
      begin
        access(1, 1'b0, 6'd2, '0, 64'hB2, 1, w);
        access(1, 1'b0, 6'd2, '0, 64'hB2, 0, w);
      end
    join
    check("t3_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("t3_grant_order", grant_log[i], exp3[i]);
    sync();
    sync();

    // Test 4: lone requester granted every cycle, then req0 wins contention
    grant_log.delete();
    wsum = 0;
    for (int i = 0; i < 4; i++) begin
      access(1, 1'b0, (i % 2 == 0) ? 6'd1 : 6'd2, '0, (i % 2 == 0) ? 64'hA1 : 64'hB2,
             (i < 3), w);
      wsum += w;
    end
    check("t4_no_idle_slots", wsum, 0);
    fork
      access(0, 1'b0, 6'd1, '0, 64'hA1, 0, w);
      begin
        int w1;
        access(1, 1'b0, 6'd2, '0, 64'hB2, 0, w1);
      end
    join
    check("t4_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("t4_grant_order", grant_log[i], exp4[i]);
    sync();
    sync();

    // Test 2: write then read-after-write, latency one
    access(0, 1'b1, 6'd5, 64'h12, '0, 0, w);
    access(0, 1'b0, 6'd5, '0, 64'h12, 0, w);
    check("t2_read_ready_same_cycle", w, 0);
    sync();
    sync();

    // Test 6: reset asserted mid-walk at clr_cnt=30
    clr_req = 1'b1;
    sync();
    clr_req = 1'b0;
    repeat (31) @(negedge clk);
    check("t6_walk_at_30", {clear_busy, mem_addr}, {1'b1, 6'd30});
    check("t6_rdata_before", bus.rsp0_rdata, 64'h12);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_busy_addr", {clear_busy, mem_we, mem_addr}, {1'b1, 1'b1, 6'd0});
    check("t6_async_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata}, 0);
    sync();
    sync();
    rst_n = 1'b1;
    clear_walk_check();
    sync();

    // Test 5: clear request alongside an accepted read
    access(0, 1'b1, 6'd9, 64'h55, '0, 0, w);
    fork
      begin
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
      end
      access(0, 1'b0, 6'd9, '0, 64'h55, 0, w);
    join
    fork
      begin
        int w5;
        access(0, 1'b0, 6'd9, '0, 64'd0, 0, w5);
        check("t5_ready_low_during_walk", w5, DEPTH);
      end
      begin
        @(negedge clk);
        check("t5_rsp_in_first_clear", {clear_busy, bus.rsp0_valid}, 2'b11);
      end
    join
    access(1, 1'b0, 6'd5, '0, 64'd0, 0, w);
    sync();
    sync();
    check("scoreboard_drained", {exp_q0.size(), exp_q1.size()}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
